// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8-N-1 UART transmitter with fractional baud accumulator.
// Define UART_TX_PARITY_EN to add a parity bit (11-bit frame, polarity set by PARITY_ODD).
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int ACC_W      = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        tx_busy,
   output logic                        TxD
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam longint INC_L = ((longint'(BAUD) <<< (ACC_W + 1)) + longint'(CLK_FREQ)) / (2 * longint'(CLK_FREQ));
   localparam logic [ACC_W:0] INC = (ACC_W + 1)'(INC_L);

   generate
      if (CLK_FREQ < 4 * BAUD) begin : g_bad_baud
         $error("uart_tx_fifo: CLK_FREQ must be at least 4*BAUD");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
      end
      if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
         $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
      end
   endgenerate

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state_q, state_d;
   logic [ACC_W:0]  acc_q, acc_d;
   logic [7:0]      shift_q, shift_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            tx_ready_q, tx_ready_d;
   logic            tx_busy_q, tx_busy_d;
   logic            txd_q, txd_d;
   logic            push, pop, tick;
   logic [7:0]      head;
   logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
   logic            par_q, par_d;
`endif

   assign head = mem_q[rd_ptr_q];

   // FIFO storage; contents need no reset because the pointers define validity
   always_ff @(posedge clk) if (push) mem_q[wr_ptr_q] <= tx_data;

   // Next-state logic: frame FSM, baud accumulator, FIFO pointers and registered outputs
   always_comb begin
      push      = tx_valid && tx_ready_q;
      tick      = acc_q[ACC_W];
      pop       = 1'b0;
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         IDLE: if (count_q != '0) begin
            pop     = 1'b1;
            state_d = START;
         end
         START: if (tick) begin
            state_d   = DATA;
            bit_cnt_d = '0;
         end
         DATA: if (tick) begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_TX_PARITY_EN
            if (bit_cnt_q == 3'd7) state_d = PARITY;
`else
            if (bit_cnt_q == 3'd7) state_d = STOP;
`endif
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (tick) state_d = STOP;
`endif
         STOP: if (tick) begin
            pop     = count_q != '0;
            state_d = (count_q != '0) ? START : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (pop) shift_d = head;
`ifdef UART_TX_PARITY_EN
      par_d = pop ? (^head ^ 1'(PARITY_ODD)) : par_q;
`endif
      // held at zero while idle so a fresh start bit always gets a full bit period
      acc_d      = (state_q == IDLE) ? '0 : {1'b0, acc_q[ACC_W-1:0]} + INC;
      wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      tx_ready_d = count_d < CW'(FIFO_DEPTH);
      tx_busy_d  = (state_d != IDLE) || (count_d != '0);
`ifdef UART_TX_PARITY_EN
      txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : (state_d == PARITY) ? par_d : 1'b1;
`else
      txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
`endif
   end

   // State and output registers; async reset drops any frame in flight and empties the FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         tx_ready_q <= 1'b1;
         tx_busy_q  <= 1'b0;
         txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         tx_ready_q <= tx_ready_d;
         tx_busy_q  <= tx_busy_d;
         txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   assign tx_ready   = tx_ready_q;
   assign fifo_count = count_q;
   assign tx_busy    = tx_busy_q;
   assign TxD        = txd_q;
endmodule
